// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] HALT_OPCODE     = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_INSTR = 4;

endpackage

// File: rtl/fetch_byte_assembler.sv
// Four-lane byte staging register plus the presented instruction register.
// The load strobe may coincide with the final lane write; the instruction
// register then takes the merged staging value in the same edge.
module fetch_byte_assembler
    import fetch_pkg::*;
#(
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [1:0]            wr_lane,
    input  logic [BYTE_WIDTH-1:0] wr_data,
    input  logic                  load,
    output logic [WORD_SIZE-1:0]  instr
);

    logic [BYTES_PER_INSTR-1:0][BYTE_WIDTH-1:0] stage_q;
    logic [BYTES_PER_INSTR-1:0][BYTE_WIDTH-1:0] stage_d;

    // Merge the incoming byte into its lane so a load sees all four bytes.
    always_comb begin
        stage_d = stage_q;
        if (wr_en) begin
            stage_d[wr_lane] = wr_data;
        end
    end

    // Staging lanes: cleared on reset or redirect, otherwise lane-written.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Presented instruction: changes only when a complete word is loaded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr <= '0;
        end else if (load) begin
            instr <= stage_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads four bytes per instruction from a
// byte-wide 1-cycle-latency memory, presents the little-endian word over a
// valid/ready handshake and accepts branch redirects.
// Optional macro FETCH_HALT_EN: an accepted 32'hFFFF_FFFF word parks the unit
// in HALTED until reset or a branch.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH),
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic [BYTE_WIDTH-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0]  instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_W-1:0]     pc,
    input  logic                  branch_en,
    input  logic [ADDR_W-1:0]     branch_target,
    output logic                  halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [1:0]        addr_off;
    logic              stage_clr;
    logic              stage_wr;
    logic [1:0]        stage_lane;
    logic              instr_load;

    // Sequential word step; wraps explicitly so non-power-of-two depths work.
    assign pc_plus4 = (pc_q == ADDR_W'(IMEM_DEPTH - BYTES_PER_INSTR))
                    ? '0 : pc_q + ADDR_W'(BYTES_PER_INSTR);

    // Byte offset saturates at 3 so the address holds pc+3 once cnt reaches 4.
    assign addr_off  = (cnt_q >= 3'd3) ? 2'd3 : cnt_q[1:0];
    assign imem_addr = pc_q + ADDR_W'(addr_off);

    assign pc          = pc_q;
    assign instr_valid = (state_q == VALID);
`ifdef FETCH_HALT_EN
    assign halted      = (state_q == HALTED);
`else
    assign halted      = 1'b0;
`endif

    // Control state register: state, PC and byte counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; branch overrides fetch progress, handshake and halt.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        stage_clr  = 1'b0;
        stage_wr   = 1'b0;
        stage_lane = cnt_q[1:0] - 2'd1;
        instr_load = 1'b0;

        if (branch_en) begin
            state_d   = FETCH;
            pc_d      = branch_target & ~ADDR_W'(3);
            cnt_d     = '0;
            stage_clr = 1'b1;
        end else begin
            case (state_q)
                FETCH: begin
                    stage_wr = (cnt_q != 3'd0);
                    if (cnt_q == 3'd4) begin
                        instr_load = 1'b1;
                        state_d    = VALID;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
`ifdef FETCH_HALT_EN
                        if (instr == HALT_OPCODE) begin
                            state_d = HALTED;
                        end else begin
                            state_d = FETCH;
                            pc_d    = pc_plus4;
                            cnt_d   = '0;
                        end
`else
                        state_d = FETCH;
                        pc_d    = pc_plus4;
                        cnt_d   = '0;
`endif
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    fetch_byte_assembler #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .WORD_SIZE  (WORD_SIZE)
    ) u_assembler (
        .clk     (clk),
        .rst     (rst),
        .clr     (stage_clr),
        .wr_en   (stage_wr),
        .wr_lane (stage_lane),
        .wr_data (imem_rdata),
        .load    (instr_load),
        .instr   (instr)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a synchronous byte
// memory model and a word-level reference built from the memory contents.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_rdata;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] pc;
    logic          branch_en;
    logic [AW-1:0] branch_target;
    logic          halted;

    logic [7:0]    mem [DEPTH];
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halted        (halted)
    );

    function automatic logic [31:0] model_word(int a);
        return {mem[(a + 3) % DEPTH], mem[(a + 2) % DEPTH],
                mem[(a + 1) % DEPTH], mem[a % DEPTH]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on cycle 0 of a fetch; valid must appear exactly 5 cycles later.
    task automatic wait_valid(string tag);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 5);
    endtask

    task automatic redirect(logic [AW-1:0] t);
        branch_en     = 1'b1;
        branch_target = t;
        tick();
        branch_en     = 1'b0;
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        int exp_pc;
        logic [31:0] held_instr;
        logic [AW-1:0] held_addr;

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 254));
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[20] = 8'hA0; mem[21] = 8'hA1; mem[22] = 8'hA2; mem[23] = 8'hA3;

        rst = 1'b0; instr_ready = 1'b0; branch_en = 1'b0; branch_target = '0;
        tick();
        tick();
        check("rst_instr", instr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_addr", imem_addr, 0);
        check("rst_pc", pc, 0);

        // First instruction with the consumer always ready.
        rst = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("first_addr", imem_addr, k);
            check("first_not_valid", instr_valid, 1'b0);
            tick();
        end
        check("first_cnt4_not_valid", instr_valid, 1'b0);
        tick();
        check("first_valid", instr_valid, 1'b1);
        check("first_instr", instr, 32'h4433_2211);
        check("first_pc", pc, 0);
        tick();
        check("first_pc_next", pc, 4);
        check("first_valid_drop", instr_valid, 1'b0);
        check("first_addr_next", imem_addr, 4);
        wait_valid("second");
        check("second_instr", instr, model_word(4));

        // Backpressure: everything holds for 10 cycles.
        instr_ready = 1'b0;
        held_instr = instr;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_instr", instr, held_instr);
            check("bp_pc", pc, 4);
            check("bp_valid", instr_valid, 1'b1);
        end
        consume();
        check("bp_pc_next", pc, 8);
        check("bp_valid_drop", instr_valid, 1'b0);

        // Randomized stall lengths against the sequential-PC model.
        exp_pc = 8;
        for (int it = 0; it < 6; it++) begin
            int stall;
            wait_valid("rand");
            check("rand_instr", instr, model_word(exp_pc));
            check("rand_pc", pc, exp_pc);
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                tick();
                check("rand_hold", instr_valid, 1'b1);
            end
            consume();
            exp_pc = (exp_pc + 4) % DEPTH;
            check("rand_pc_next", pc, exp_pc);
        end

        // Wrap at the top of memory.
        redirect(6'd60);
        check("wrap_pc", pc, 60);
        for (int k = 0; k < 4; k++) begin
            check("wrap_addr", imem_addr, 60 + k);
            tick();
        end
        tick();
        check("wrap_valid", instr_valid, 1'b1);
        check("wrap_instr", instr, model_word(60));
        consume();
        check("wrap_pc_next", pc, 0);
        check("wrap_addr_next", imem_addr, 0);

        // Branch in the middle of a fetch (cnt==2), unaligned target.
        tick();
        tick();
        redirect(6'd22);
        check("midbr_pc", pc, 20);
        check("midbr_addr", imem_addr, 20);
        check("midbr_valid", instr_valid, 1'b0);
        wait_valid("midbr");
        check("midbr_instr", instr, 32'hA3A2_A1A0);
        consume();
        check("midbr_pc_next", pc, 24);

        // Branch together with handshake: target wins over pc+4.
        redirect(6'd4);
        wait_valid("sim8_pre");
        instr_ready = 1'b1; branch_en = 1'b1; branch_target = 6'd8;
        tick();
        instr_ready = 1'b0; branch_en = 1'b0;
        check("sim8_pc", pc, 8);
        check("sim8_valid", instr_valid, 1'b0);
        wait_valid("sim8");
        check("sim8_instr", instr, model_word(8));
        redirect(6'd4);
        wait_valid("sim32_pre");
        instr_ready = 1'b1; branch_en = 1'b1; branch_target = 6'd32;
        tick();
        instr_ready = 1'b0; branch_en = 1'b0;
        check("sim32_pc", pc, 32);
        wait_valid("sim32");
        check("sim32_instr", instr, model_word(32));
        check("sim32_pc_hold", pc, 32);

        // All-ones word at address 8.
        mem[8] = 8'hFF; mem[9] = 8'hFF; mem[10] = 8'hFF; mem[11] = 8'hFF;
        redirect(6'd8);
        wait_valid("ones");
        check("ones_instr", instr, 32'hFFFF_FFFF);
        consume();
`ifdef FETCH_HALT_EN
        check("halt_flag", halted, 1'b1);
        check("halt_valid", instr_valid, 1'b0);
        check("halt_pc", pc, 8);
        held_addr = imem_addr;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("halt_addr_frozen", imem_addr, held_addr);
            check("halt_stays", halted, 1'b1);
        end
        redirect(6'd0);
        check("halt_exit", halted, 1'b0);
        check("halt_exit_pc", pc, 0);
        wait_valid("resume");
        check("resume_instr", instr, 32'h4433_2211);
`else
        held_addr = imem_addr;
        check("ones_not_halted", halted, 1'b0);
        check("ones_pc_next", pc, 12);
        check("ones_addr_next", held_addr, 12);
        wait_valid("after_ones");
        check("after_ones_instr", instr, model_word(12));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage between the byte-wide synchronous instruction memory (8-bit data, 64 entries) and the control unit.
- Owns the program counter and issues four consecutive byte addresses per instruction.
- Assembles the four returned bytes little-endian into one 32-bit instruction.
- Presents the instruction to the control unit over a valid/ready handshake and accepts branch redirects.

Parameters:
- WORD_SIZE, 32, instruction width; must equal 4*BYTE_WIDTH.
- BYTE_WIDTH, 8, instruction memory data width.
- IMEM_DEPTH, 64, instruction memory entries; must be a multiple of 4.
- ADDR_W, $clog2(IMEM_DEPTH), byte address width.
- RESET_PC, 0, PC value after reset; must be word-aligned.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- imem_addr  out  ADDR_W  byte address to instruction memory
- imem_rdata  in  BYTE_WIDTH  memory read data, valid one cycle after imem_addr
- instr  out  WORD_SIZE  assembled instruction
- instr_valid  out  1  instr is complete and stable
- instr_ready  in  1  control unit accepts instr
- pc  out  ADDR_W  byte address of the instruction held or being fetched
- branch_en  in  1  redirect request, single-cycle pulse or level
- branch_target  in  ADDR_W  redirect address; bits [1:0] ignored (forced 0)
- halted  out  1  fetch halted; tied 0 without FETCH_HALT_EN

Behaviour:
- Reset (rst==0 at a clock edge):
  - pc=RESET_PC, state=FETCH, cnt=0.
  - instr=0, instr_valid=0, halted=0, imem_addr=RESET_PC.
  - Reset mid-fetch discards all partial bytes.
- Memory latency is a fixed 1 cycle: the byte for the address driven in cycle N is captured at the end of cycle N+1.
- States: FETCH, VALID (plus HALTED under the macro). cnt is 3 bits, range 0..4.
- FETCH:
  - imem_addr = pc + cnt for cnt 0..3, wrapping modulo IMEM_DEPTH; imem_addr holds pc+3 at cnt==4.
  - When cnt in 1..4, capture imem_rdata into instr byte lane cnt-1 (lane 0 = bits[7:0]).
  - cnt increments every cycle.
  - At cnt==4, next state is VALID.
- Latency: instr_valid asserts 5 cycles after entering FETCH. instr is updated only on the FETCH→VALID edge; partial bytes live in a staging register.
- VALID:
  - instr_valid=1; instr and pc held stable until handshake.
  - On instr_valid && instr_ready: pc <= pc+4 (wraps to 0 past IMEM_DEPTH-4), state=FETCH, cnt=0.
  - instr_valid deasserts on the next cycle.
  - Throughput: one instruction per 6 cycles with instr_ready held high.
- Branch (branch_en==1 in any state):
  - pc <= {branch_target[ADDR_W-1:2],2'b00}, state=FETCH, cnt=0.
  - Staging bytes discarded; instr_valid=0 next cycle.
- Branch simultaneous with handshake: the handshake completes (instruction consumed) and the branch target overrides pc+4.
- Branch takes priority over FETCH progression and over the HALTED state.
- Wrap-around: pc = IMEM_DEPTH-4 followed by an accept gives pc=0.
- No combinational path from instr_ready or branch_en to instr_valid or instr.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Enabled:
  - An assembled instruction equal to 32'hFFFF_FFFF is still presented in VALID.
  - On its handshake the unit enters HALTED instead of FETCH: halted=1, pc unchanged, no further fetch, instr_valid=0, imem_addr held.
  - HALTED exits only on reset (halted=0) or branch_en (to FETCH, halted=0).
- Disabled: HALTED state absent, halted tied 0, 32'hFFFF_FFFF treated as an ordinary instruction.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_t {FETCH, VALID, HALTED}
  - localparam HALT_OPCODE = 32'hFFFF_FFFF
  - localparam BYTES_PER_INSTR = 4
- One sub-module, fetch_byte_assembler:
  - 4-lane staging register with lane-select write enable, clear, and a load strobe into the instr output register.
- FSM and PC stay in the top module.

Test Plan:
- Reset then run with instr_ready=1, memory bytes 0..3 = 11,22,33,44 → imem_addr sequence 0,1,2,3; instr=32'h44332211 with instr_valid high at cycle 5; pc=0; then pc=4.
- Backpressure: instr_ready=0 for 10 cycles while valid → instr, pc and instr_valid stable; accept on cycle 11 → pc advances by exactly 4.
- Wrap: RESET_PC=60 → fetch addresses 60..63, accept → pc=0, next imem_addr=0.
- Branch at cnt==2 with branch_target=6'd22 → pc=20, partial bytes discarded, next instr assembled from addresses 20..23 only.
- Simultaneous instr_ready=1 and branch_en=1, target=8, pc=4 → instruction consumed exactly once, next pc=8 (not 8 via pc+4 coincidence; repeat with target=32).
- FETCH_HALT_EN: word FF FF FF FF at address 8 → presented valid, halted=1 after accept; imem_addr frozen 20 cycles; branch_en to 0 clears halted and fetch resumes.
